// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the writeback request payload and the depth helper.
package rf_pkg;

   localparam int unsigned DW_DEF = 8;
   localparam int unsigned PW_DEF = 2;
   localparam int unsigned NR_DEF = 3;

   // Writeback request as issued by the ALU / load pipes.
   typedef struct packed {
      logic              en;
      logic [PW_DEF-1:0] addr;
      logic [DW_DEF-1:0] data;
   } wr_req_t;

   function automatic int unsigned rf_depth(input int unsigned pw);
      return 32'(1) << pw;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for multi-cycle producers: set by lock, cleared by
// writeback, with a new lock overriding a same-cycle completion.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned PW      = PW_DEF,
   parameter int unsigned NR      = NR_DEF,
   parameter bit          ZERO_R0 = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lock_en,
   input  logic [PW-1:0]    lock_addr,
   input  logic             clr_en0,
   input  logic [PW-1:0]    clr_addr0,
   input  logic             clr_en1,
   input  logic [PW-1:0]    clr_addr1,
   input  logic [NR*PW-1:0] rd_addr,
   output logic [NR-1:0]    busy_out,
   output logic             any_busy
);

   localparam int unsigned DEPTH = rf_depth(PW);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   // Clears first, then the lock so a new producer wins over a completing one.
   always_comb begin
      busy_nxt = busy;
      if (clr_en0) busy_nxt[clr_addr0] = 1'b0;
      if (clr_en1) busy_nxt[clr_addr1] = 1'b0;
      if (lock_en) busy_nxt[lock_addr] = 1'b1;
      if (ZERO_R0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   for (genvar i = 0; i < int'(NR); i++) begin : g_busy
      assign busy_out[i] = busy[rd_addr[i*PW +: PW]];
   end

   assign any_busy = |busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NR combinational
// read ports with optional write-through bypass and optional hardwired R0.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned PW      = PW_DEF,
   parameter int unsigned NR      = NR_DEF,
   parameter bit          BYPASS  = 1'b1,
   parameter bit          ZERO_R0 = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en0,
   input  logic [PW-1:0]    wr_addr0,
   input  logic [DW-1:0]    dat_in0,
   input  logic             wr_en1,
   input  logic [PW-1:0]    wr_addr1,
   input  logic [DW-1:0]    dat_in1,
   input  logic             lock_en,
   input  logic [PW-1:0]    lock_addr,
   input  logic [NR*PW-1:0] rd_addr,
   output logic [NR*DW-1:0] dat_out,
   output logic [NR-1:0]    busy_out,
   output logic             any_busy
);

   localparam int unsigned DEPTH = rf_depth(PW);

   logic [DW-1:0] core [DEPTH];
   logic          we0;
   logic          we1;
   logic          lk;

   // With a hardwired R0, traffic to address 0 is simply dropped.
   assign we0 = wr_en0  && !(ZERO_R0 && (wr_addr0  == '0));
   assign we1 = wr_en1  && !(ZERO_R0 && (wr_addr1  == '0));
   assign lk  = lock_en && !(ZERO_R0 && (lock_addr == '0));

   // Port 1 is written last so it wins on an address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         core <= '{default: '0};
      end else begin
         if (we0) core[wr_addr0] <= dat_in0;
         if (we1) core[wr_addr1] <= dat_in1;
      end
   end

   for (genvar i = 0; i < int'(NR); i++) begin : g_rd
      logic [PW-1:0] ra;
      logic [DW-1:0] rd;

      assign ra = rd_addr[i*PW +: PW];

      always_comb begin
         rd = core[ra];
         if (BYPASS && !reset) begin
            if (we0 && (wr_addr0 == ra)) rd = dat_in0;
            if (we1 && (wr_addr1 == ra)) rd = dat_in1;
         end
         if (ZERO_R0 && (ra == '0)) rd = '0;
      end

      assign dat_out[i*DW +: DW] = rd;
   end

   rf_scoreboard #(
      .PW      (PW),
      .NR      (NR),
      .ZERO_R0 (ZERO_R0)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .lock_en   (lk),
      .lock_addr (lock_addr),
      .clr_en0   (we0),
      .clr_addr0 (wr_addr0),
      .clr_en1   (we1),
      .clr_addr1 (wr_addr1),
      .rd_addr   (rd_addr),
      .busy_out  (busy_out),
      .any_busy  (any_busy)
   );

endmodule
